uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a
//               show-ahead byte FIFO with sticky overrun/frame/parity flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_bit_end  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_baud_one = CW'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW:0]   c_depth    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic            r_sync1_q, r_sync2_q;
    state_t          r_state_q, w_state_d;
    logic [CW-1:0]   r_baud_q, w_baud_d;
    logic [2:0]      r_bit_q, w_bit_d;
    logic [7:0]      r_shift_q, w_shift_d;
    logic            r_push_q, w_push_d;
    logic [AW-1:0]   r_wptr_q, w_wptr_d;
    logic [AW-1:0]   r_rptr_q, w_rptr_d;
    logic [AW:0]     r_count_q, w_count_d;
    logic            r_overrun_q, w_overrun_d;
    logic            r_frame_err_q, w_frame_err_d;
    logic [7:0]      r_mem_q [FIFO_DEPTH];

    logic            w_frame_evt;
    logic            w_pop, w_wr, w_drop, w_full;

`ifdef UART_RX_PARITY_EN
    logic            r_par_bad_q, w_par_bad_d;
    logic            r_parity_err_q, w_parity_err_d;
    logic            w_par_evt;
`endif

    // Receive framing FSM; runs only on the synchronised line.
    always_comb begin
        w_state_d   = r_state_q;
        w_baud_d    = r_baud_q + c_baud_one;
        w_bit_d     = r_bit_q;
        w_shift_d   = r_shift_q;
        w_push_d    = 1'b0;
        w_frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_d = r_par_bad_q;
        w_par_evt   = 1'b0;
`endif
        case (r_state_q)
            S_IDLE: begin
                w_baud_d = '0;
                w_bit_d  = '0;
`ifdef UART_RX_PARITY_EN
                w_par_bad_d = 1'b0;
`endif
                if (!r_sync2_q) w_state_d = S_START;
            end
            S_START: begin
                if (r_baud_q == c_half) begin
                    w_baud_d  = '0;
                    w_state_d = r_sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud_q == c_bit_end) begin
                    w_baud_d  = '0;
                    w_shift_d = {r_sync2_q, r_shift_q[7:1]};
                    w_bit_d   = r_bit_q + 3'd1;
                    if (r_bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_d = S_PARITY;
`else
                        w_state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_baud_q == c_bit_end) begin
                    w_baud_d    = '0;
                    w_state_d   = S_STOP;
                    w_par_bad_d = (r_sync2_q != ^r_shift_q);
                    w_par_evt   = (r_sync2_q != ^r_shift_q);
                end
            end
`endif
            S_STOP: begin
                if (r_baud_q == c_bit_end) begin
                    w_baud_d  = '0;
                    w_state_d = S_IDLE;
                    if (!r_sync2_q) begin
                        w_frame_evt = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (!r_par_bad_q) begin
`else
                    end else begin
`endif
                        w_push_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_baud_d  = '0;
            end
        endcase
    end

    // A push into a full FIFO succeeds only when a pop frees a slot this cycle.
    always_comb begin
        w_full    = (r_count_q == c_depth);
        w_pop     = rd_en && (r_count_q != '0);
        w_wr      = r_push_q && (!w_full || w_pop);
        w_drop    = r_push_q && w_full && !w_pop;
        w_wptr_d  = w_wr  ? r_wptr_q + c_ptr_one : r_wptr_q;
        w_rptr_d  = w_pop ? r_rptr_q + c_ptr_one : r_rptr_q;
        w_count_d = r_count_q;
        if (w_wr && !w_pop)      w_count_d = r_count_q + c_cnt_one;
        else if (!w_wr && w_pop) w_count_d = r_count_q - c_cnt_one;
        w_overrun_d   = (r_overrun_q   && !clr_err) || w_drop;
        w_frame_err_d = (r_frame_err_q && !clr_err) || w_frame_evt;
`ifdef UART_RX_PARITY_EN
        w_parity_err_d = (r_parity_err_q && !clr_err) || w_par_evt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1_q     <= 1'b1;
            r_sync2_q     <= 1'b1;
            r_state_q     <= S_IDLE;
            r_baud_q      <= '0;
            r_bit_q       <= '0;
            r_shift_q     <= '0;
            r_push_q      <= 1'b0;
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_count_q     <= '0;
            r_overrun_q   <= 1'b0;
            r_frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad_q    <= 1'b0;
            r_parity_err_q <= 1'b0;
`endif
        end else begin
            r_sync1_q     <= uart_rx;
            r_sync2_q     <= r_sync1_q;
            r_state_q     <= w_state_d;
            r_baud_q      <= w_baud_d;
            r_bit_q       <= w_bit_d;
            r_shift_q     <= w_shift_d;
            r_push_q      <= w_push_d;
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_count_q     <= w_count_d;
            r_overrun_q   <= w_overrun_d;
            r_frame_err_q <= w_frame_err_d;
`ifdef UART_RX_PARITY_EN
            r_par_bad_q    <= w_par_bad_d;
            r_parity_err_q <= w_parity_err_d;
`endif
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (rst && w_wr) r_mem_q[r_wptr_q] <= r_shift_q;
    end

    assign rd_data   = r_mem_q[r_rptr_q];
    assign rx_valid  = (r_count_q != '0);
    assign rx_count  = r_count_q;
    assign overrun   = r_overrun_q;
    assign frame_err = r_frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo (4 clks/bit, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count),
        .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        cycles(CPB);
    endtask

    // Full frame; the parity bit is only sent when use_par is set.
    task automatic send(input logic [7:0] d, input logic stop, input logic use_par, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(par);
        drive_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
        send(d, 1'b1, 1'b1, ^d);
`else
        send(d, 1'b1, 1'b0, 1'b0);
`endif
        cycles(2 * CPB);
    endtask

    task automatic pop;
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errors;
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(2);
        n_tests++;
        if ({rx_valid, rx_count, overrun, frame_err, parity_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b count=%0d ov=%b fe=%b pe=%b, want all 0",
                     rx_valid, rx_count, overrun, frame_err, parity_err);
        end
    endtask

    task automatic test_basic;
        send_byte(8'hA5);
        n_tests++;
        if (rx_valid !== 1'b1 || rx_count !== 3'd1 || rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_rx: got valid=%b count=%0d data=%h, want 1 1 a5", rx_valid, rx_count, rd_data);
        end
        pop();
        n_tests++;
        if (rx_valid !== 1'b0 || rx_count !== 3'd0 || {overrun, frame_err, parity_err} !== 3'b0) begin
            n_fail++;
            $display("FAIL basic_pop: got valid=%b count=%0d flags=%b, want 0 0 000",
                     rx_valid, rx_count, {overrun, frame_err, parity_err});
        end
        pop();
        n_tests++;
        if (rx_count !== 3'd0) begin
            n_fail++;
            $display("FAIL empty_pop: got count=%0d, want 0", rx_count);
        end
    endtask

    // Pop asserted exactly on the FIFO write edge (second edge after the stop bit ends).
    task automatic send_with_pop(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
        send(d, 1'b1, 1'b1, ^d);
`else
        send(d, 1'b1, 1'b0, 1'b0);
`endif
        cycles(1);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        cycles(2);
    endtask

    task automatic test_empty_push_pop;
        send_with_pop(8'h3E);
        n_tests++;
        if (rx_count !== 3'd1 || rd_data !== 8'h3E) begin
            n_fail++;
            $display("FAIL empty_push_pop: got count=%0d data=%h, want 1 3e", rx_count, rd_data);
        end
        pop();
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        n_tests++;
        if (rx_count !== 3'd4 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_fill: got count=%0d ov=%b, want 4 1", rx_count, overrun);
        end
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (rd_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL overrun_pop%0d: got %h, want %h", i, rd_data, 8'(i));
            end
            pop();
        end
        n_tests++;
        if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got count=%0d valid=%b, want 0 0", rx_count, rx_valid);
        end
        send_byte(8'h06);
        n_tests++;
        if (rd_data !== 8'h06 || rx_count !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap: got data=%h count=%0d, want 06 1", rd_data, rx_count);
        end
        pop();
        clear_errors();
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        end
    endtask

    task automatic test_full_push_pop;
        for (int i = 7; i <= 10; i++) send_byte(8'(i));
        send_with_pop(8'h0B);
        n_tests++;
        if (rx_count !== 3'd4 || overrun !== 1'b0 || rd_data !== 8'h08) begin
            n_fail++;
            $display("FAIL full_push_pop: got count=%0d ov=%b data=%h, want 4 0 08", rx_count, overrun, rd_data);
        end
        for (int i = 8; i <= 11; i++) begin
            n_tests++;
            if (rd_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL full_drain%0d: got %h, want %h", i, rd_data, 8'(i));
            end
            pop();
        end
    endtask

    task automatic test_frame_err;
`ifdef UART_RX_PARITY_EN
        send(8'h3C, 1'b0, 1'b1, ^8'h3C);
`else
        send(8'h3C, 1'b0, 1'b0, 1'b0);
`endif
        cycles(3 * CPB);
        n_tests++;
        if (frame_err !== 1'b1 || rx_count !== 3'd0) begin
            n_fail++;
            $display("FAIL frame_err_set: got fe=%b count=%0d, want 1 0", frame_err, rx_count);
        end
        clear_errors();
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_clear: got %b, want 0", frame_err);
        end
    endtask

    task automatic test_glitch;
        uart_rx = 1'b0;
        cycles(1);
        uart_rx = 1'b1;
        cycles(5 * CPB);
        n_tests++;
        if (rx_count !== 3'd0 || {overrun, frame_err, parity_err} !== 3'b0) begin
            n_fail++;
            $display("FAIL glitch: got count=%0d flags=%b, want 0 000", rx_count, {overrun, frame_err, parity_err});
        end
        send_byte(8'h42);
        n_tests++;
        if (rx_count !== 3'd1 || rd_data !== 8'h42) begin
            n_fail++;
            $display("FAIL glitch_recover: got count=%0d data=%h, want 1 42", rx_count, rd_data);
        end
        pop();
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rst = 1'b0;
        cycles(2);
        uart_rx = 1'b1;
        cycles(1);
        rst = 1'b1;
        cycles(2);
        send_byte(8'h11);
        n_tests++;
        if (rx_count !== 3'd1 || rd_data !== 8'h11 || {overrun, frame_err, parity_err} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got count=%0d data=%h flags=%b, want 1 11 000",
                     rx_count, rd_data, {overrun, frame_err, parity_err});
        end
        pop();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        send(8'h07, 1'b1, 1'b1, 1'b0);
        cycles(2 * CPB);
        n_tests++;
        if (parity_err !== 1'b1 || rx_count !== 3'd0) begin
            n_fail++;
            $display("FAIL parity_bad: got pe=%b count=%0d, want 1 0", parity_err, rx_count);
        end
        clear_errors();
        send(8'h07, 1'b1, 1'b1, 1'b1);
        cycles(2 * CPB);
        n_tests++;
        if (parity_err !== 1'b0 || rx_count !== 3'd1 || rd_data !== 8'h07) begin
            n_fail++;
            $display("FAIL parity_good: got pe=%b count=%0d data=%h, want 0 1 07", parity_err, rx_count, rd_data);
        end
        pop();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_empty_push_pop();
        test_overrun();
        test_full_push_pop();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
